// File: rtl/game_tab_ctrl.sv
// Write-side controller for the 40x30x4b game table RAM (port B).
// Executes WRITE / MOVE / CLEAR commands only during vertical blank so frames never tear.
module game_tab_ctrl #(
  parameter int TAB_W       = 40,
  parameter int TAB_H       = 30,
  parameter int VISIBLEROWS = 480,
  parameter int VTOTAL      = 525,
  parameter int YC_LSB      = 10,   // position of the YC field inside RGBStr_i
  parameter int YC_W        = 10
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic [25:0] RGBStr_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_x,
  input  logic [4:0]  cmd_y,
  input  logic [1:0]  cmd_dir,
  input  logic [3:0]  cmd_val,
  output logic [10:0] TabBAdd,
  output logic [3:0]  TabBDat_o,
  output logic        TabBWe,
  input  logic [3:0]  TabBDat_i,
  output logic        done,
  output logic [1:0]  status
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WAIT = 4'd1;
  localparam logic [3:0] S_WR   = 4'd2;
  localparam logic [3:0] S_RD_S = 4'd3;
  localparam logic [3:0] S_RD_D = 4'd4;
  localparam logic [3:0] S_CHK  = 4'd5;
  localparam logic [3:0] S_WR_D = 4'd6;
  localparam logic [3:0] S_WR_S = 4'd7;
  localparam logic [3:0] S_CLR  = 4'd8;
  localparam logic [3:0] S_DONE = 4'd9;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BLOCKED = 2'b01;
  localparam logic [1:0] ST_RANGE   = 2'b10;

  localparam logic [10:0]     W11     = 11'(TAB_W);
  localparam logic [10:0]     LAST    = 11'(TAB_W * TAB_H - 1);
  localparam logic [YC_W-1:0] Y_VIS   = YC_W'(VISIBLEROWS);
  localparam logic [YC_W-1:0] Y_GUARD = YC_W'(VTOTAL - 1);

  logic [3:0]  r_state, w_next;
  logic [1:0]  r_op, r_dir, r_status, w_status;
  logic [5:0]  r_x, w_dx;
  logic [4:0]  r_y, w_dy;
  logic [3:0]  r_val, r_src_val, r_wdat, w_wdat;
  logic [10:0] r_addr, w_addr, w_src, w_dst;
  logic        r_blank, r_we, r_done, w_we, w_off, w_range_err, w_blank_d;
  logic [YC_W-1:0] w_yc;
  logic        w_unused;

  assign w_yc      = RGBStr_i[YC_LSB +: YC_W];
  assign w_unused  = &{1'b0, RGBStr_i};
  assign w_blank_d = (w_yc >= Y_VIS) && (w_yc < Y_GUARD);

  assign w_src       = 11'(r_y) * W11 + 11'(r_x);
  assign w_dst       = 11'(w_dy) * W11 + 11'(w_dx);
  assign w_range_err = (r_x >= 6'(TAB_W)) || (r_y >= 5'(TAB_H)) || (r_op == 2'b11);

  // Destination cell of a MOVE; w_off flags an edge-of-table move (no wrap).
  always_comb begin
    w_dx  = r_x;
    w_dy  = r_y;
    w_off = 1'b0;
    case (r_dir)
      2'b00: begin w_off = (r_y == 5'd0);            w_dy = r_y - 5'd1; end
      2'b01: begin w_off = (r_y == 5'(TAB_H - 1));   w_dy = r_y + 5'd1; end
      2'b10: begin w_off = (r_x == 6'd0);            w_dx = r_x - 6'd1; end
      default: begin w_off = (r_x == 6'(TAB_W - 1)); w_dx = r_x + 6'd1; end
    endcase
  end

  // Port-B outputs are registered from the next state so address, data and
  // write enable line up with the state that owns them.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_next   = r_state;
    w_addr   = r_addr;
    w_wdat   = r_wdat;
    w_we     = 1'b0;
    w_status = r_status;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_WAIT;
      S_WAIT: begin
        if (w_range_err) begin
          w_next   = S_DONE;
          w_status = ST_RANGE;
        end else if (r_blank && w_blank_d) begin
          case (r_op)
            2'b00: begin w_next = S_WR;   w_addr = w_src; w_wdat = r_val; w_we = 1'b1; end
            2'b01: begin w_next = S_RD_S; w_addr = w_src; end
            default: begin w_next = S_CLR; w_addr = '0; w_wdat = r_val; w_we = 1'b1; end
          endcase
        end
      end
      S_WR: begin w_next = S_DONE; w_status = ST_OK; end
      S_RD_S: begin
        w_next = S_RD_D;
        w_addr = w_off ? w_src : w_dst;
      end
      S_RD_D: w_next = S_CHK;
      // Destination cell is on TabBDat_i during CHK.
      S_CHK: begin
        if ((r_src_val == 4'd0) || w_off || (TabBDat_i != 4'd0)) begin
          w_next   = S_DONE;
          w_status = ST_BLOCKED;
        end else begin
          w_next = S_WR_D;
          w_addr = w_dst;
          w_wdat = r_src_val;
          w_we   = 1'b1;
        end
      end
      S_WR_D: begin w_next = S_WR_S; w_addr = w_src; w_wdat = 4'd0; w_we = 1'b1; end
      S_WR_S: begin w_next = S_DONE; w_status = ST_OK; end
      S_CLR: begin
        w_we = w_blank_d;
        if (r_we) begin
          if (r_addr == LAST) begin
            w_next   = S_DONE;
            w_status = ST_OK;
            w_we     = 1'b0;
          end else begin
            w_addr = r_addr + 11'd1;
          end
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_blank   <= 1'b0;
      r_op      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_dir     <= '0;
      r_val     <= '0;
      r_src_val <= '0;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_status  <= ST_OK;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state  <= w_next;
      r_blank  <= w_blank_d;
      r_addr   <= w_addr;
      r_wdat   <= w_wdat;
      r_we     <= w_we;
      r_done   <= (w_next == S_DONE);
      r_status <= w_status;
      if (r_state == S_IDLE && cmd_valid) begin
        r_op  <= cmd_op;
        r_x   <= cmd_x;
        r_y   <= cmd_y;
        r_dir <= cmd_dir;
        r_val <= cmd_val;
      end
      if (r_state == S_RD_D) r_src_val <= TabBDat_i;
    end
  end

  // Gated by rst_n so the controller refuses commands while held in reset.
  assign cmd_ready = rst_n && (r_state == S_IDLE);
  assign TabBAdd   = r_addr;
  assign TabBDat_o = r_wdat;
  assign TabBWe    = r_we;
  assign done      = r_done;
  assign status    = r_status;

endmodule

// File: tb/tb_game_tab_ctrl.sv
// Self-checking bench for game_tab_ctrl: table-driven commands plus hand-written
// latency, vertical-blank, CLEAR-pause and reset sequences, with a write/status scoreboard.
module tb_game_tab_ctrl;

  localparam int ROW_CYC = 32;
  localparam int VTOT    = 525;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] RGBStr;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_dir, status;
  logic [5:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [3:0]  cmd_val, TabBDat_o, TabBDat_i;
  logic [10:0] TabBAdd;
  logic        TabBWe, done;

  game_tab_ctrl dut (
    .px_clk(clk), .rst_n(rst_n), .RGBStr_i(RGBStr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_dir(cmd_dir), .cmd_val(cmd_val),
    .TabBAdd(TabBAdd), .TabBDat_o(TabBDat_o), .TabBWe(TabBWe),
    .TabBDat_i(TabBDat_i), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  // Table RAM, port B: synchronous read (read-before-write), synchronous write.
  logic [3:0] mem [0:2047];
  logic [3:0] ram_q;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 4'd0;
    ram_q = 4'd0;
  end
  always @(posedge clk) begin
    if (TabBWe) mem[TabBAdd] <= TabBDat_o;
    ram_q <= mem[TabBAdd];
  end
  assign TabBDat_i = ram_q;

  // Pixel stream: YC lives in bits [19:10]; other bits carry junk.
  logic [9:0] yc;
  int         pix;
  assign RGBStr = {6'h2a, yc, 10'h155};

  // Reference registered blank.
  logic tb_blank = 1'b0;
  always @(posedge clk) tb_blank <= (yc >= 10'd480) && (yc < 10'd524);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int n_we     = 0;
  int n_done   = 0;
  int last_we_cyc, last_done_cyc, acc_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [10:0] a;
    logic [3:0]  d;
    bit          mv;
  } wexp_t;

  wexp_t      wq[$];
  logic [1:0] sq[$];

  task automatic push_w(input logic [10:0] a, input logic [3:0] d, input bit mv);
    wexp_t e;
    e.a = a; e.d = d; e.mv = mv;
    wq.push_back(e);
  endtask

  // Scoreboard: compare every write and every done against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (TabBWe) begin
        wexp_t e;
        n_we++;
        last_we_cyc = cyc_cnt;
        check("write_pending", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("write_addr_data", {17'd0, TabBAdd, TabBDat_o}, {17'd0, e.a, e.d});
          if (!e.mv) check("we_in_blank", 32'(tb_blank), 1);
        end
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc_cnt;
        check("done_pending", 32'(sq.size() != 0), 1);
        if (sq.size() != 0) check("status", 32'(status), 32'(sq.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    cyc_cnt++;
    #1;
    pix++;
    if (pix == ROW_CYC) begin
      pix = 0;
      yc  = (yc == 10'(VTOT - 1)) ? 10'd0 : yc + 10'd1;
    end
  endtask

  task automatic set_yc(input logic [9:0] v);
    yc  = v;
    pix = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] x, input logic [4:0] y,
                       input logic [1:0] dir, input logic [3:0] val);
    int k = 0;
    while (!cmd_ready && k < 100) begin cyc(); k++; end
    check("cmd_ready_seen", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_dir = dir; cmd_val = val;
    cyc();
    acc_edge  = cyc_cnt;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k = 0;
    while (n_done <= base && k < budget) begin cyc(); k++; end
    check("done_seen", 32'(n_done > base), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(TabBWe), 0);
    check({tag, "_addr"},  32'(TabBAdd), 0);
    check({tag, "_dat"},   32'(TabBDat_o), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_stat"},  32'(status), 0);
    check({tag, "_ready"}, 32'(cmd_ready), 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [1:0]  dir;
    logic [3:0]  val;
    logic [1:0]  st;
    int          nw;
    logic [10:0] a0;
    logic [3:0]  d0;
    logic [10:0] a1;
    logic [3:0]  d1;
  } vec_t;

  vec_t vec [22];

  initial begin
    int base, w0, k;
    vec = '{
      '{2'd0, 6'd5,  5'd2,  2'd0, 4'd7, 2'd0, 1, 11'd85,   4'd7, 11'd0,    4'd0},
      '{2'd0, 6'd10, 5'd10, 2'd0, 4'd3, 2'd0, 1, 11'd410,  4'd3, 11'd0,    4'd0},
      '{2'd1, 6'd10, 5'd10, 2'd3, 4'd0, 2'd0, 2, 11'd411,  4'd3, 11'd410,  4'd0},
      '{2'd0, 6'd10, 5'd10, 2'd0, 4'd3, 2'd0, 1, 11'd410,  4'd3, 11'd0,    4'd0},
      '{2'd0, 6'd11, 5'd10, 2'd0, 4'd5, 2'd0, 1, 11'd411,  4'd5, 11'd0,    4'd0},
      '{2'd1, 6'd10, 5'd10, 2'd3, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd39, 5'd0,  2'd0, 4'd8, 2'd0, 1, 11'd39,   4'd8, 11'd0,    4'd0},
      '{2'd1, 6'd39, 5'd0,  2'd3, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd40, 5'd0,  2'd0, 4'd1, 2'd2, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd0,  5'd30, 2'd0, 4'd1, 2'd2, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd3, 6'd1,  5'd1,  2'd0, 4'd1, 2'd2, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd1, 6'd0,  5'd5,  2'd0, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd0,  5'd28, 2'd0, 4'd9, 2'd0, 1, 11'd1120, 4'd9, 11'd0,    4'd0},
      '{2'd1, 6'd0,  5'd28, 2'd1, 4'd0, 2'd0, 2, 11'd1160, 4'd9, 11'd1120, 4'd0},
      '{2'd1, 6'd0,  5'd29, 2'd1, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd1,  5'd0,  2'd0, 4'd2, 2'd0, 1, 11'd1,    4'd2, 11'd0,    4'd0},
      '{2'd1, 6'd1,  5'd0,  2'd2, 4'd0, 2'd0, 2, 11'd0,    4'd2, 11'd1,    4'd0},
      '{2'd1, 6'd0,  5'd0,  2'd2, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd0, 6'd3,  5'd1,  2'd0, 4'd4, 2'd0, 1, 11'd43,   4'd4, 11'd0,    4'd0},
      '{2'd1, 6'd3,  5'd1,  2'd0, 4'd0, 2'd0, 2, 11'd3,    4'd4, 11'd43,   4'd0},
      '{2'd1, 6'd3,  5'd0,  2'd0, 4'd0, 2'd1, 0, 11'd0,    4'd0, 11'd0,    4'd0},
      '{2'd1, 6'd63, 5'd0,  2'd3, 4'd0, 2'd2, 0, 11'd0,    4'd0, 11'd0,    4'd0}
    };

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_dir = '0; cmd_val = '0;
    set_yc(10'd0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(cmd_ready), 1);

    // WRITE latency with blank already active.
    set_yc(10'd490);
    cyc(); cyc();
    base = n_done;
    push_w(11'd125, 4'd6, 1'b0);
    sq.push_back(2'b00);
    issue(2'd0, 6'd5, 5'd3, 2'd0, 4'd6);
    wait_done(base, 20);
    check("we_latency", 32'(last_we_cyc - acc_edge), 1);
    check("done_latency", 32'(last_done_cyc - acc_edge), 2);

    // Table-driven commands, all inside one blank window.
    set_yc(10'd480);
    cyc(); cyc();
    for (int i = 0; i < 22; i++) begin
      base = n_done;
      if (vec[i].nw > 0) push_w(vec[i].a0, vec[i].d0, vec[i].op == 2'd1);
      if (vec[i].nw > 1) push_w(vec[i].a1, vec[i].d1, 1'b1);
      sq.push_back(vec[i].st);
      issue(vec[i].op, vec[i].x, vec[i].y, vec[i].dir, vec[i].val);
      wait_done(base, 40);
      check("vec_writes_drained", 32'(wq.size()), 0);
    end

    // WRITE issued in the visible area waits for blank.
    set_yc(10'd100);
    cyc();
    base = n_done;
    w0   = n_we;
    push_w(11'd122, 4'd4, 1'b0);
    sq.push_back(2'b00);
    issue(2'd0, 6'd2, 5'd3, 2'd0, 4'd4);
    check("ready_low_in_wait", 32'(cmd_ready), 0);
    k = 0;
    while (yc != 10'd480 && k < 20000) begin cyc(); k++; end
    check("no_write_before_blank", 32'(n_we - w0), 0);
    wait_done(base, 100);
    check("wait_write_drained", 32'(wq.size()), 0);

    // CLEAR started near the guard row: pauses, finishes next frame.
    set_yc(10'd520);
    cyc();
    base = n_done;
    w0   = n_we;
    for (int a = 0; a < 1200; a++) push_w(11'(a), 4'd0, 1'b0);
    sq.push_back(2'b00);
    issue(2'd2, 6'd0, 5'd0, 2'd0, 4'd0);
    k = 0;
    while (yc != 10'd100 && k < 20000) begin cyc(); k++; end
    check("clear_paused", 32'((n_we - w0 > 0) && (n_we - w0 < 1200)), 1);
    wait_done(base, 40000);
    repeat (3) cyc();
    check("clear_write_count", 32'(n_we - w0), 1200);
    check("clear_done_count", 32'(n_done - base), 1);
    check("clear_drained", 32'(wq.size()), 0);

    // Reset mid-MOVE, after the destination write.
    set_yc(10'd490);
    cyc();
    base = n_done;
    push_w(11'd820, 4'd6, 1'b0);
    sq.push_back(2'b00);
    issue(2'd0, 6'd20, 5'd20, 2'd0, 4'd6);
    wait_done(base, 20);
    base = n_done;
    sq.push_back(2'b10);
    issue(2'd0, 6'd40, 5'd1, 2'd0, 4'd6);
    wait_done(base, 20);
    push_w(11'd821, 4'd6, 1'b1);
    push_w(11'd820, 4'd0, 1'b1);
    w0 = n_we;
    issue(2'd1, 6'd20, 5'd20, 2'd3, 4'd0);
    k = 0;
    while (n_we == w0 && k < 20) begin cyc(); @(negedge clk); #1; k++; end
    check("move_wr_d_seen", 32'(n_we - w0), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("move_rst");
    wq.delete();
    sq.delete();
    cyc(); cyc();
    check("move_rst_we_held", 32'(TabBWe), 0);
    rst_n = 1'b1;
    #1;
    check("move_rst_ready", 32'(cmd_ready), 1);

    // Reset mid-CLEAR leaves the table partially filled.
    cyc();
    w0 = n_we;
    for (int a = 0; a < 1200; a++) push_w(11'(a), 4'd15, 1'b0);
    sq.push_back(2'b00);
    issue(2'd2, 6'd0, 5'd0, 2'd0, 4'd15);
    k = 0;
    while (n_we - w0 < 50 && k < 200) begin cyc(); k++; end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("clr_rst");
    wq.delete();
    sq.delete();
    cyc(); cyc();
    check("clr_rst_we_held", 32'(TabBWe), 0);
    rst_n = 1'b1;
    #1;
    check("clr_rst_ready", 32'(cmd_ready), 1);
    check("clr_partial_first", 32'(mem[0]), 15);
    check("clr_partial_last", 32'(mem[1199]), 0);

    // A fresh WRITE after reset completes normally.
    set_yc(10'd490);
    cyc(); cyc();
    base = n_done;
    push_w(11'd287, 4'd9, 1'b0);
    sq.push_back(2'b00);
    issue(2'd0, 6'd7, 5'd7, 2'd0, 4'd9);
    wait_done(base, 20);
    check("final_drained", 32'(wq.size()), 0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_tab_ctrl.md
Name: game_tab_ctrl

Overview:
Command-driven controller that owns the write side of the 40x30x4b game table RAM, with port B of a true dual-port RAM. The display pipeline reads port A continuously. The block accepts WRITE, MOVE and CLEAR commands from game logic through a valid/ready handshake. It executes table updates only during a vertical-blank window derived from the pixel stream, so displayed frames never tear.

Parameters:
TAB_W, 40, table columns
TAB_H, 30, table rows
VISIBLEROWS, 480, first non-visible row (YC)
VTOTAL, 525, rows per frame; row VTOTAL-1 is a guard row (no updates)

Ports:
px_clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
RGBStr_i  in  26  pixel stream; only the YC field (Pxs.vh macro) is used
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 WRITE, 01 MOVE, 10 CLEAR, 11 reserved (treated as error)
cmd_x  in  6  cell column
cmd_y  in  5  cell row
cmd_dir  in  2  MOVE direction: 00 up(y-1), 01 down(y+1), 10 left(x-1), 11 right(x+1)
cmd_val  in  4  WRITE data; CLEAR fill value
TabBAdd  out  11  port B address = y*TAB_W + x
TabBDat_o  out  4  port B write data
TabBWe  out  1  port B write enable
TabBDat_i  in  4  port B read data, valid 1 cycle after address
done  out  1  one-cycle pulse when a command completes
status  out  2  00 ok, 01 blocked, 10 range error; valid with done, held until next done

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=0 during reset and 1 in the first cycle after release. TabBAdd=0, TabBDat_o=0, TabBWe=0, done=0, status=00. Reset mid-command abandons the command; no further writes occur, and a partially cleared table stays partial.
- blank = (YC >= VISIBLEROWS) && (YC < VTOTAL-1), registered one cycle.
- Handshake: the command is captured on the px_clk edge where cmd_valid && cmd_ready, then state goes to WAIT. cmd_ready=0 until the return to IDLE. A single command is outstanding at a time.
- Range check in WAIT: x>=TAB_W, y>=TAB_H or op=11 -> DONE with status 10, no RAM access.
- WAIT: holds while blank=0. When blank=1, dispatches on op.
- WRITE: WR (TabBWe=1, addr=src, data=cmd_val) -> DONE, status 00.
- MOVE sequence:
  - RD_S: addr=src.
  - RD_D: addr=dst; capture the src cell.
  - CHK: capture the dst cell.
  - Blocked if any of: src cell==0, dst off-table (x=0 left, x=TAB_W-1 right, y=0 up, y=TAB_H-1 down; no wrap), or dst cell!=0. Blocked -> DONE with status 01, no writes.
  - Otherwise WR_D (write src value to dst) -> WR_S (write 0 to src) -> DONE, status 00.
  - MOVE is atomic once started; the guard row guarantees completion before row 0.
- CLEAR: CLR writes cmd_val to addresses 0..TAB_W*TAB_H-1 ascending, one per cycle.
  - If blank drops, TabBWe=0 and the address counter holds; it resumes at the same address next blank.
  - After address 1199 is written -> DONE, status 00.
- DONE: done=1 for one cycle, status updated -> IDLE.
- TabBWe is high only in WR, WR_D, WR_S, and CLR-with-blank; it is never high while blank=0 except during an in-flight MOVE.
- Address arithmetic is 11-bit unsigned; max 1199.
- Latency: WRITE accepted at edge T with blank already 1 -> TabBWe high in cycle T+2, done in T+3.

Test Plan:
- Blank=1, WRITE x=5 y=2 val=7 -> single TabBWe with TabBAdd=85, data 7; done 3 cycles after accept, status 00.
- WRITE issued at YC=100 -> cmd_ready=0, no TabBWe until YC=480; then write, done, status 00.
- MOVE from (10,10)=3 right, (11,10)=0 -> writes addr 411<=3 then 410<=0, status 00. Repeat with (11,10)=5 -> no writes, status 01.
- MOVE (39,0) right, and WRITE x=40 -> status 01 and 10 respectively, TabBWe never asserted.
- CLEAR val=0 started at YC=520 -> writes pause at YC=524; remaining addresses written next frame; exactly 1200 distinct writes total, one done.
- rst_n low mid-CLEAR and mid-MOVE (after WR_D) -> TabBWe drops immediately, all outputs 0; after release cmd_ready=1 and a new WRITE completes normally.
